outerprodrc_drain: RTL

- Reader at the output end of the unary outer-product array.
- Takes the per-cycle ROWNUM x COLNUM matrix of binary partial counts produced by the array.
- Accumulates those counts over one full bitstream period of CYCLES enabled cycles.
- Then streams the final matrix out one element per handshake (row-major) to the downstream buffer/writeback.

---
 rtl/outerprodrc_drain.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/outerprodrc_drain.sv
`default_nettype none
// ============================================================================
// Module      : outerprodrc_drain
// Description : Output reader for the unary outer-product array. Sums the
//               per-cycle ROWNUM x COLNUM partial-count matrix over CYCLES
//               enabled cycles, then streams the accumulated matrix out
//               row-major, one element per valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module outerprodrc_drain #(
  parameter int ROWNUM   = 2,
  parameter int COLNUM   = 2,
  parameter int INWIDTH  = 4,
  parameter int CYCLES   = 256,
  parameter int ACCWIDTH = 12,
  parameter int IDXWIDTH = 2
) (
  input  logic                                iClk,
  input  logic                                iRstN,
  input  logic                                iClr,
  input  logic                                iStart,
  input  logic                                iEn,
  input  logic [ROWNUM*COLNUM*INWIDTH-1:0]    iData,
  output logic                                oValid,
  input  logic                                iReady,
  output logic [ACCWIDTH-1:0]                 oData,
  output logic [IDXWIDTH-1:0]                 oIdx,
  output logic                                oBusy,
  output logic                                oDone
);

  localparam int NUM  = ROWNUM * COLNUM;
  // A single-cycle period still needs a one-bit counter to compare against.
  localparam int CNTW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNTW-1:0]     CNT_LAST = CNTW'(CYCLES - 1);
  localparam logic [IDXWIDTH-1:0] IDX_LAST = IDXWIDTH'(NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACCWIDTH-1:0]   acc_q [NUM];
  logic [ACCWIDTH-1:0]   acc_d [NUM];
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [IDXWIDTH-1:0]   idx_q, idx_d;
  logic                  done_q, done_d;
  logic [ACCWIDTH-1:0]   out_data;

  // State register: synchronous active-low reset clears everything.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int e = 0; e < NUM; e++) begin
        acc_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      for (int e = 0; e < NUM; e++) begin
        acc_q[e] <= acc_d[e];
      end
    end
  end

  // Next-state logic: accumulate in ACC, walk the index in DRAIN; a clear
  // request overrides whatever the state machine decided this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    for (int e = 0; e < NUM; e++) begin
      acc_d[e] = acc_q[e];
    end

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_ACC;
          for (int e = 0; e < NUM; e++) begin
            acc_d[e] = '0;
          end
        end
      end

      S_ACC: begin
        if (iEn) begin
          for (int e = 0; e < NUM; e++) begin
            acc_d[e] = acc_q[e] + ACCWIDTH'(iData[e*INWIDTH +: INWIDTH]);
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (iReady) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (iClr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      for (int e = 0; e < NUM; e++) begin
        acc_d[e] = '0;
      end
    end
  end

  // Output mux: present acc[idx] only while draining, zero otherwise.
  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int e = 0; e < NUM; e++) begin
        if (idx_q == IDXWIDTH'(e)) begin
          out_data = acc_q[e];
        end
      end
    end
  end

  assign oValid = (state_q == S_DRAIN);
  assign oData  = out_data;
  assign oIdx   = idx_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = done_q;

endmodule
`default_nettype wire
